kbd_player_ctrl: RTL and testbench
==================================

KBD_PLAYER_CTRL -- requirements
Module: kbd_player_ctrl

Interface
REQ-001 Parameter FIRE_PERIOD, default 5000000, clk cycles between auto-repeat fire pulses while a fire key is held; legal range 2..2^24-1.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 resetN  input  1  asynchronous, active-low reset.
REQ-004 keyCode  input  9  key code of the current event, {extended, scan byte}; valid in the cycle make or brake is high.
REQ-005 make  input  1  one-cycle strobe: key pressed (typematic repeats arrive as further make strobes).
REQ-006 brake  input  1  one-cycle strobe: key released.
REQ-007 p1_dir  output  3  player-1 direction: 0 none, 1 up, 2 down, 3 left, 4 right.
REQ-008 p2_dir  output  3  player-2 direction, same encoding as p1_dir.
REQ-009 p1_fire  output  1  one-cycle player-1 fire pulse.
REQ-010 p2_fire  output  1  one-cycle player-2 fire pulse.
REQ-011 any_held  output  1  high while any mapped key is held.

Function
REQ-012 The key map SHALL be as follows:
- P1: up 0x175, down 0x172, left 0x16B, right 0x174, fire 0x114.
- P2: up 0x01D, down 0x01B, left 0x01C, right 0x023, fire 0x014.
- Any other code is ignored without changing state.
REQ-013 Each player SHALL keep 4 direction-held bits, a fire-held bit and a 3-bit current direction.
REQ-014 A make of an unheld direction key SHALL set its held bit and make it the current direction, so the last-pressed key wins.
REQ-015 A make of an already-held key (typematic) SHALL change nothing and SHALL NOT generate a fire pulse.
REQ-016 A brake of a non-current held direction SHALL clear its bit only.
REQ-017 A brake of the current direction SHALL clear its bit and select the remaining held key by fixed priority up>down>left>right, or 0 if none is held.
REQ-018 A brake of an unheld key SHALL be ignored.
REQ-019 make and brake high in the same cycle SHALL be ignored entirely.
REQ-020 Outputs SHALL be registered; p*_dir and any_held SHALL reflect an event in the cycle after its strobe (latency 1).
REQ-021 The fire make edge (fire-held 0->1) SHALL produce exactly one fire pulse, 1 cycle after the strobe.
REQ-022 The per-player fire FSM SHALL have states F_IDLE, F_HOLD:
- F_IDLE->F_HOLD on fire make, which loads a 24-bit counter to FIRE_PERIOD-1.
- F_HOLD->F_IDLE on fire brake, which clears the counter and emits no pulse.
REQ-023 Players are fully independent; one player's events SHALL NOT alter the other player's state.

Reset
REQ-024 resetN low SHALL asynchronously clear all held bits, counters and FSMs to F_IDLE, and force all outputs to 0.
REQ-025 Reset mid-hold SHALL forget all held keys; a later brake for such a key is an unheld brake and is ignored.

Configuration
REQ-026 Macro KBD_FIRE_AUTOREPEAT_EN:
- Defined: in F_HOLD the counter decrements each cycle; at 0 it emits one fire pulse and reloads FIRE_PERIOD-1, so pulses repeat every FIRE_PERIOD cycles.
- Undefined: no counter logic exists; fire pulses occur only on fire-held 0->1 edges.

Structure
REQ-027 Package kbd_player_pkg SHALL hold the dir_t enum (NONE, UP, DOWN, LEFT, RIGHT), the ten key-code localparams and the fire-state enum.
REQ-028 Sub-module kbd_player_track SHALL implement one player (held bits, direction select, fire FSM, counter), parameterised by its five key codes; the top SHALL instantiate it twice and OR the held flags into any_held.

Verification (FIRE_PERIOD=8)
REQ-029 Make 0x175 -> p1_dir=1 next cycle; brake 0x175 -> p1_dir=0 and any_held=0.
REQ-030 Make 0x01C, make 0x023, brake 0x023 -> p2_dir goes 3, then 4, then 3.
REQ-031 Hold 0x16B and 0x174, brake 0x174 -> p1_dir=3; then also make 0x175, brake 0x175 -> p1_dir=3.
REQ-032 Make 0x014 held 20 cycles with macro defined -> pulses at +1, +9, +17; macro undefined -> single pulse; three typematic makes during the hold -> no extra pulses.
REQ-033 Make and brake simultaneous with 0x114, or a make of 0x05A -> no output change.
REQ-034 Hold 0x172, assert resetN low mid-hold -> all outputs 0 at once; a subsequent brake 0x172 -> still 0.

Source files
------------

// File: rtl/kbd_player_pkg.sv
// Shared types, key map and direction-priority helper for the keyboard player controller.
package kbd_player_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } dir_t;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_HOLD = 1'b1
  } fire_state_t;

  localparam logic [8:0] P1_UP    = 9'h175;
  localparam logic [8:0] P1_DOWN  = 9'h172;
  localparam logic [8:0] P1_LEFT  = 9'h16B;
  localparam logic [8:0] P1_RIGHT = 9'h174;
  localparam logic [8:0] P1_FIRE  = 9'h114;

  localparam logic [8:0] P2_UP    = 9'h01D;
  localparam logic [8:0] P2_DOWN  = 9'h01B;
  localparam logic [8:0] P2_LEFT  = 9'h01C;
  localparam logic [8:0] P2_RIGHT = 9'h023;
  localparam logic [8:0] P2_FIRE  = 9'h014;

  // Held vectors are ordered [0]=up [1]=down [2]=left [3]=right; the lowest set bit wins.
  function automatic dir_t prio_dir(input logic [3:0] held);
    prio_dir = NONE;
    for (int i = 3; i >= 0; i--) begin
      if (held[i]) prio_dir = dir_t'(3'(i + 1));
    end
  endfunction

endpackage

// File: rtl/kbd_player_track.sv
// One player's key tracking: held bits, last-pressed direction select and fire FSM.
// KBD_FIRE_AUTOREPEAT_EN adds a reload counter that repeats fire pulses while held.
module kbd_player_track
  import kbd_player_pkg::*;
#(
  parameter int unsigned FIRE_PERIOD = 5000000,
  parameter logic [8:0]  KEY_UP      = P1_UP,
  parameter logic [8:0]  KEY_DOWN    = P1_DOWN,
  parameter logic [8:0]  KEY_LEFT    = P1_LEFT,
  parameter logic [8:0]  KEY_RIGHT   = P1_RIGHT,
  parameter logic [8:0]  KEY_FIRE    = P1_FIRE
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [8:0] key_code,
  input  logic       make,
  input  logic       brake,
  output dir_t       dir,
  output logic       fire,
  output logic       held
);

  logic [3:0]  dir_held, dir_held_d;
  dir_t        cur_dir, cur_dir_d;
  fire_state_t fire_state;
  logic [3:0]  key_dir;
  logic        mk, bk, fire_mk, fire_bk, fire_hold_d;

  // Simultaneous make and brake is treated as no event.
  always_comb begin
    mk      = make & ~brake;
    bk      = brake & ~make;
    key_dir = {key_code == KEY_RIGHT, key_code == KEY_LEFT,
               key_code == KEY_DOWN,  key_code == KEY_UP};
    fire_mk = mk & (key_code == KEY_FIRE);
    fire_bk = bk & (key_code == KEY_FIRE);
  end

  always_comb begin
    dir_held_d = dir_held;
    cur_dir_d  = cur_dir;
    if (mk && ((key_dir & ~dir_held) != 4'b0)) begin
      dir_held_d = dir_held | key_dir;
      cur_dir_d  = prio_dir(key_dir);
    end else if (bk && ((key_dir & dir_held) != 4'b0)) begin
      dir_held_d = dir_held & ~key_dir;
      if (prio_dir(key_dir) == cur_dir) cur_dir_d = prio_dir(dir_held & ~key_dir);
    end
    fire_hold_d = (fire_state == F_IDLE) ? fire_mk : ~fire_bk;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      dir_held <= 4'b0;
      cur_dir  <= NONE;
      held     <= 1'b0;
    end else begin
      dir_held <= dir_held_d;
      cur_dir  <= cur_dir_d;
      held     <= (|dir_held_d) | fire_hold_d;
    end
  end

  assign dir = cur_dir;

`ifdef KBD_FIRE_AUTOREPEAT_EN
  localparam logic [23:0] RELOAD = 24'(FIRE_PERIOD - 1);
  logic [23:0] fire_cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fire_state <= F_IDLE;
      fire_cnt   <= 24'd0;
      fire       <= 1'b0;
    end else begin
      fire <= 1'b0;
      unique case (fire_state)
        F_IDLE: begin
          if (fire_mk) begin
            fire_state <= F_HOLD;
            fire_cnt   <= RELOAD;
            fire       <= 1'b1;
          end
        end
        F_HOLD: begin
          if (fire_bk) begin
            fire_state <= F_IDLE;
            fire_cnt   <= 24'd0;
          end else if (fire_cnt == 24'd0) begin
            fire     <= 1'b1;
            fire_cnt <= RELOAD;
          end else begin
            fire_cnt <= fire_cnt - 24'd1;
          end
        end
        default: fire_state <= F_IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fire_state <= F_IDLE;
      fire       <= 1'b0;
    end else begin
      fire <= 1'b0;
      unique case (fire_state)
        F_IDLE: begin
          if (fire_mk) begin
            fire_state <= F_HOLD;
            fire       <= 1'b1;
          end
        end
        F_HOLD: if (fire_bk) fire_state <= F_IDLE;
        default: fire_state <= F_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: rtl/kbd_player_ctrl.sv
// Two-player keyboard controller: decodes make/brake events into per-player direction and fire.
// Optional fire auto-repeat is enabled with KBD_FIRE_AUTOREPEAT_EN.
module kbd_player_ctrl
  import kbd_player_pkg::*;
#(
  parameter int unsigned FIRE_PERIOD = 5000000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [8:0] keyCode,
  input  logic       make,
  input  logic       brake,
  output logic [2:0] p1_dir,
  output logic [2:0] p2_dir,
  output logic       p1_fire,
  output logic       p2_fire,
  output logic       any_held
);

  dir_t p1_dir_e, p2_dir_e;
  logic p1_held, p2_held;

  kbd_player_track #(
    .FIRE_PERIOD(FIRE_PERIOD),
    .KEY_UP     (P1_UP),
    .KEY_DOWN   (P1_DOWN),
    .KEY_LEFT   (P1_LEFT),
    .KEY_RIGHT  (P1_RIGHT),
    .KEY_FIRE   (P1_FIRE)
  ) u_p1 (
    .clk     (clk),
    .resetN  (resetN),
    .key_code(keyCode),
    .make    (make),
    .brake   (brake),
    .dir     (p1_dir_e),
    .fire    (p1_fire),
    .held    (p1_held)
  );

  kbd_player_track #(
    .FIRE_PERIOD(FIRE_PERIOD),
    .KEY_UP     (P2_UP),
    .KEY_DOWN   (P2_DOWN),
    .KEY_LEFT   (P2_LEFT),
    .KEY_RIGHT  (P2_RIGHT),
    .KEY_FIRE   (P2_FIRE)
  ) u_p2 (
    .clk     (clk),
    .resetN  (resetN),
    .key_code(keyCode),
    .make    (make),
    .brake   (brake),
    .dir     (p2_dir_e),
    .fire    (p2_fire),
    .held    (p2_held)
  );

  assign p1_dir   = p1_dir_e;
  assign p2_dir   = p2_dir_e;
  assign any_held = p1_held | p2_held;

endmodule

// File: tb/tb_kbd_player_ctrl.sv
// Randomised bench for kbd_player_ctrl against a key-set reference model (FIRE_PERIOD = 8).
module tb_kbd_player_ctrl;

  localparam int PERIOD = 8;
`ifdef KBD_FIRE_AUTOREPEAT_EN
  localparam bit AUTO_REPEAT = 1'b1;
`else
  localparam bit AUTO_REPEAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetN;
  logic [8:0] keyCode;
  logic       make, brake;
  logic [2:0] p1_dir, p2_dir;
  logic       p1_fire, p2_fire, any_held;

  kbd_player_ctrl #(.FIRE_PERIOD(PERIOD)) dut (
    .clk     (clk),
    .resetN  (resetN),
    .keyCode (keyCode),
    .make    (make),
    .brake   (brake),
    .p1_dir  (p1_dir),
    .p2_dir  (p2_dir),
    .p1_fire (p1_fire),
    .p2_fire (p2_fire),
    .any_held(any_held)
  );

  always #5 clk = ~clk;

  // Key table per player: up, down, left, right, fire.
  logic [8:0] keys [2][5] = '{'{9'h175, 9'h172, 9'h16B, 9'h174, 9'h114},
                              '{9'h01D, 9'h01B, 9'h01C, 9'h023, 9'h014}};

  // Reference model: set of held keys, last-pressed direction, cycles since fire press.
  bit m_held [2][4];
  int m_cur  [2];
  bit m_fheld[2];
  int m_age  [2];
  bit m_fire [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) m_held[p][i] = 1'b0;
      m_cur[p] = 0; m_fheld[p] = 1'b0; m_age[p] = 0; m_fire[p] = 1'b0;
    end
  endfunction

  function automatic void model_edge(input logic [8:0] code, input bit mk, input bit bk);
    int pl = -1, idx = -1;
    bit ev;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 5; k++)
        if (keys[p][k] == code) begin pl = p; idx = k; end
    ev = (mk != bk) && (pl >= 0);
    for (int p = 0; p < 2; p++) begin
      m_fire[p] = 1'b0;
      if (ev && pl == p && idx == 4 && mk && !m_fheld[p]) begin
        m_fheld[p] = 1'b1; m_age[p] = 0; m_fire[p] = 1'b1;
      end else if (ev && pl == p && idx == 4 && bk && m_fheld[p]) begin
        m_fheld[p] = 1'b0;
      end else if (m_fheld[p]) begin
        m_age[p]++;
        if (AUTO_REPEAT && (m_age[p] % PERIOD == 0)) m_fire[p] = 1'b1;
      end
    end
    if (ev && idx < 4) begin
      if (mk && !m_held[pl][idx]) begin
        m_held[pl][idx] = 1'b1;
        m_cur[pl] = idx + 1;
      end else if (bk && m_held[pl][idx]) begin
        m_held[pl][idx] = 1'b0;
        if (m_cur[pl] == idx + 1) begin
          m_cur[pl] = 0;
          for (int i = 0; i < 4; i++) if (m_held[pl][i] && m_cur[pl] == 0) m_cur[pl] = i + 1;
        end
      end
    end
  endfunction

  function automatic int model_any();
    int a = 0;
    for (int p = 0; p < 2; p++) begin
      if (m_fheld[p]) a = 1;
      for (int i = 0; i < 4; i++) if (m_held[p][i]) a = 1;
    end
    return a;
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, ".p1_dir"},   int'(p1_dir),   m_cur[0]);
    check_eq({tag, ".p2_dir"},   int'(p2_dir),   m_cur[1]);
    check_eq({tag, ".p1_fire"},  int'(p1_fire),  int'(m_fire[0]));
    check_eq({tag, ".p2_fire"},  int'(p2_fire),  int'(m_fire[1]));
    check_eq({tag, ".any_held"}, int'(any_held), model_any());
  endtask

  // Present one event for one clock, then compare outputs just after the edge.
  task automatic step(input string tag, input logic [8:0] code, input bit mk, input bit bk);
    keyCode = code; make = mk; brake = bk;
    @(posedge clk);
    model_edge(code, mk, bk);
    #1;
    make = 1'b0; brake = 1'b0;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 9'h000, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges; outputs must drop before any clock arrives.
  task automatic mid_reset(input string tag);
    #2 resetN = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    #2 resetN = 1'b1;
  endtask

  int pulses;

  initial begin
    resetN = 1'b0; keyCode = 9'h0; make = 1'b0; brake = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    resetN = 1'b1;

    // Single key make/brake.
    step("p1_up_make",  9'h175, 1, 0);
    step("p1_up_brake", 9'h175, 0, 1);

    // Last pressed wins, then falls back to the remaining key.
    step("p2_left",  9'h01C, 1, 0);
    step("p2_right", 9'h023, 1, 0);
    step("p2_rbrk",  9'h023, 0, 1);
    check_eq("p2_fallback", int'(p2_dir), 3);
    step("p2_lbrk",  9'h01C, 0, 1);

    // Priority on brake of current direction.
    step("p1_l", 9'h16B, 1, 0);
    step("p1_r", 9'h174, 1, 0);
    step("p1_rb", 9'h174, 0, 1);
    step("p1_u", 9'h175, 1, 0);
    step("p1_ub", 9'h175, 0, 1);
    check_eq("p1_prio_left", int'(p1_dir), 3);
    step("p1_lb", 9'h16B, 0, 1);

    // Fire hold with typematic repeats.
    pulses = 0;
    keyCode = 9'h014; make = 1'b1;
    @(posedge clk); model_edge(9'h014, 1, 0); #1; make = 1'b0;
    check_outputs("fire_make");
    pulses += int'(p2_fire);
    for (int i = 1; i < 20; i++) begin
      if (i == 4 || i == 9 || i == 13) step("fire_typematic", 9'h014, 1, 0);
      else step("fire_hold", 9'h000, 0, 0);
      pulses += int'(p2_fire);
    end
    check_eq("fire_pulse_count", pulses, AUTO_REPEAT ? 3 : 1);
    step("fire_brake", 9'h014, 0, 1);
    idle("fire_after", 10);

    // Ignored events.
    step("p1_fire_both", 9'h114, 1, 1);
    step("unmapped", 9'h05A, 1, 0);
    step("unheld_brake", 9'h172, 0, 1);

    // Reset mid-hold forgets the key.
    step("hold_down", 9'h172, 1, 0);
    mid_reset("reset_mid_hold");
    step("brake_after_reset", 9'h172, 0, 1);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [8:0] code;
      bit mk, bk;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        mid_reset("rand_reset");
        continue;
      end
      if ($urandom_range(0, 99) < 85) code = keys[$urandom_range(0, 1)][$urandom_range(0, 4)];
      else code = 9'($urandom_range(0, 511));
      r = $urandom_range(0, 9);
      mk = (r <= 2) || (r == 6);
      bk = (r >= 3 && r <= 5) || (r == 6);
      step("rand", code, mk, bk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
